seq_comparator: RTL and testbench
=================================

Name: seq_comparator

Overview:
Parametrised, multi-cycle successor to the combinational comparator, for wide operands (e.g. 64/128-bit address and CSR compares) where a full-width compare would break timing. It compares CHUNK bits per cycle, starting at the most significant chunk, and stops at the first differing chunk. It uses valid/ready handshakes on both sides and the codebase sign_t (SIGNED/UNSIGNED) for mode. It also supports a synchronous flush.

Parameters:
LEN, 64, operand width in bits.
CHUNK, 16, bits compared per cycle; must divide LEN evenly (elaboration-time assertion).
NCHUNK, LEN/CHUNK, derived localparam; number of chunks.
CW, $clog2(NCHUNK+1), derived localparam; width of out_chunks.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-high.
flush  in  1  synchronous abort of any in-flight or pending compare.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
in_sign  in  sign_t  SIGNED or UNSIGNED compare.
in_src1  in  LEN  first operand.
in_src2  in  LEN  second operand.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_eq  out  1  src1 == src2.
out_lt  out  1  src1 < src2 under in_sign.
out_ge  out  1  always !out_lt.
out_chunks  out  CW  number of chunks examined, 1..NCHUNK.

Behaviour:
- States: IDLE, BUSY, DONE; 2-bit state register.
- in_ready = (state==IDLE) && !flush. Acceptance occurs when in_valid && in_ready.
- On acceptance:
  - Capture operands into a1/a2.
  - If in_sign==SIGNED, invert the MSB of both captured operands (bias). All later compares are unsigned.
  - idx <= NCHUNK-1; cnt <= 0; state <= BUSY.
- BUSY, each cycle:
  - c1 = a1[idx*CHUNK +: CHUNK], c2 likewise; cnt increments.
  - If c1 != c2: lt_r <= (c1 < c2); eq_r <= 0; state <= DONE.
  - Else if idx == 0: eq_r <= 1; lt_r <= 0; state <= DONE.
  - Else idx <= idx-1.
- DONE:
  - out_valid = 1. out_eq, out_lt, out_ge and out_chunks come from registers and stay stable until handshake.
  - On out_valid && out_ready: state <= IDLE.
- Latency:
  - Accept in cycle 0. BUSY occupies cycles 1..k, where k = index of first differing chunk from the top, or NCHUNK if equal.
  - out_valid first high in cycle k+1. Minimum 2, maximum NCHUNK+1.
  - Back-to-back throughput: one request per k+2 cycles. No accept in DONE.
- NCHUNK==1 (CHUNK==LEN): a single BUSY cycle, identical to a full-width registered compare.
- flush:
  - Highest priority.
  - In IDLE it blocks acceptance.
  - In BUSY or DONE it drops the work: state <= IDLE, and out_valid is low next cycle.
  - flush together with out_ready in DONE counts as a drop, not a consume; the result is identical either way.
- Reset (async, any state, including mid-compare):
  - state=IDLE, idx=0, cnt=0, eq_r=0, lt_r=0.
  - Hence out_valid=0, out_eq=0, out_lt=0, out_ge=1, out_chunks=0.
  - in_ready=1 once rst is released (0 if flush is high).
- Operand and sign inputs are ignored outside the acceptance cycle. Input changes during BUSY do not affect the result.
- Equal-magnitude signed corner: 0x8000…0 vs 0x8000…0 gives eq=1, lt=0. Most-negative vs 0 gives lt=1.

Test Plan:
- LEN=64, CHUNK=16, UNSIGNED, 0x0123456789ABCDEF vs the same value -> eq=1, lt=0, ge=1, out_chunks=4, out_valid 5 cycles after accept.
- SIGNED, 0x8000000000000000 vs 0x0000000000000001 -> lt=1, ge=0, eq=0, out_chunks=1, out_valid at cycle 2. The same operands with UNSIGNED -> lt=0, ge=1, out_chunks=1.
- UNSIGNED, 0x000000000000FFFF vs 0x0000000000010000 -> lt=1, out_chunks=3. SIGNED, 0xFFFFFFFFFFFFFFFF (-1) vs 0xFFFFFFFFFFFFFFFE (-2) -> lt=0, ge=1, out_chunks=4.
- Backpressure: result ready, out_ready held low 5 cycles -> out_valid, eq/lt/chunks stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, and a new request is accepted on the following cycle.
- flush asserted in the 2nd BUSY cycle of an equal-operand compare -> no out_valid ever for that request; in_ready=1 the cycle after flush deasserts. flush together with in_valid in IDLE -> no accept.
- rst pulsed asynchronously (mid-cycle) during BUSY -> outputs immediately out_valid=0, out_eq=0, out_lt=0, out_ge=1, out_chunks=0; the next request completes correctly.

Source files
------------

// File: rtl/seq_comparator.sv
// Multi-cycle wide-operand magnitude comparator: CHUNK bits per cycle, MSB chunk first,
// early exit on the first differing chunk, valid/ready on both sides plus synchronous flush.

package seq_comparator_pkg;
    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } sign_t;
endpackage

module seq_comparator_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] c1,
    input  logic [CHUNK-1:0] c2,
    output logic             ne,
    output logic             lt
);
    assign ne = (c1 != c2);
    assign lt = (c1 < c2);
endmodule

module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter  int LEN    = 64,
    parameter  int CHUNK  = 16,
    localparam int NCHUNK = LEN / CHUNK,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  sign_t          in_sign,
    input  logic [LEN-1:0] in_src1,
    input  logic [LEN-1:0] in_src2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_eq,
    output logic           out_lt,
    output logic           out_ge,
    output logic [CW-1:0]  out_chunks
);
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [LEN-1:0] BIAS = {1'b1, {(LEN-1){1'b0}}};

    if ((CHUNK < 1) || (LEN % CHUNK != 0)) begin : g_bad_chunk
        $error("seq_comparator: CHUNK must evenly divide LEN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state;
    logic [NCHUNK-1:0][CHUNK-1:0]  a1, a2;
    logic [IW-1:0]                 idx;
    logic [CW-1:0]                 cnt;
    logic                          eq_r, lt_r;
    logic [NCHUNK-1:0]             ne_v, lt_v;

    // Every chunk has its own comparator; BUSY just picks the one under idx.
    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        seq_comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
            .c1 (a1[g]),
            .c2 (a2[g]),
            .ne (ne_v[g]),
            .lt (lt_v[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a1    <= '0;
            a2    <= '0;
            idx   <= '0;
            cnt   <= '0;
            eq_r  <= 1'b0;
            lt_r  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping both MSBs maps two's complement order onto unsigned order.
                        a1    <= (in_sign == SIGNED) ? (in_src1 ^ BIAS) : in_src1;
                        a2    <= (in_sign == SIGNED) ? (in_src2 ^ BIAS) : in_src2;
                        idx   <= IW'(NCHUNK - 1);
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (ne_v[idx]) begin
                        lt_r  <= lt_v[idx];
                        eq_r  <= 1'b0;
                        state <= DONE;
                    end else if (idx == '0) begin
                        eq_r  <= 1'b1;
                        lt_r  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE) && !flush;
    assign out_valid  = (state == DONE);
    assign out_eq     = eq_r;
    assign out_lt     = lt_r;
    assign out_ge     = !lt_r;
    assign out_chunks = cnt;

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_eq) && $stable(out_lt) && $stable(out_chunks)));

    a_chunks: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_chunks >= CW'(1)) && (out_chunks <= CW'(NCHUNK)));
endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: driver pushes model results, negedge monitor pops on handshake.
module tb_seq_comparator;
    import seq_comparator_pkg::*;

    localparam int LEN    = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = LEN / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);

    logic           clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic           out_eq, out_lt, out_ge;
    logic [CW-1:0]  out_chunks;
    logic [LEN-1:0] in_src1, in_src2;
    sign_t          in_sign;

    seq_comparator #(.LEN(LEN), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_eq(out_eq), .out_lt(out_lt), .out_ge(out_ge), .out_chunks(out_chunks)
    );

    typedef struct {
        logic   eq;
        logic   lt;
        int     ch;
        longint acc;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0, n_fail = 0;
    int     bp_mode = 0;
    longint cyc = 0;
    logic   prev_v = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic compare; chunk count from the highest differing bit.
    function automatic exp_t model(input sign_t s, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        exp_t e;
        logic [LEN-1:0] x;
        int p;
        e.eq = (a == b);
        e.lt = (s == SIGNED) ? ($signed(a) < $signed(b)) : (a < b);
        x = a ^ b;
        p = -1;
        for (int i = 0; i < LEN; i++) if (x[i]) p = i;
        e.ch  = (p < 0) ? NCHUNK : NCHUNK - p / CHUNK;
        e.acc = 0;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input sign_t s, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         output int waits);
        exp_t e;
        bit   done;
        e = model(s, a, b);
        in_valid = 1'b1; in_sign = s; in_src1 = a; in_src2 = b;
        done = 1'b0; waits = 0;
        while (!done && waits < 300) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc;
                q.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sign  = sign_t'($urandom_range(0, 1));
        in_src1  = {$urandom, $urandom};
        in_src2  = {$urandom, $urandom};
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", (q.size() == 0), 1);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !prev_v) begin
                if (q.size() == 0) check("unexpected_valid", 1, 0);
                else check("latency", cyc - q[0].acc, q[0].ch + 1);
            end
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("eq", out_eq, e.eq);
                    check("lt", out_lt, e.lt);
                    check("ge", out_ge, !e.lt);
                    check("chunks", out_chunks, e.ch);
                end
            end
        end
        prev_v <= out_valid;
    end

    initial begin
        int w, n;
        exp_t e;
        logic [LEN-1:0] a, b, m;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sign = UNSIGNED;
        in_src1 = '0; in_src2 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_eq", out_eq, 0);
        check("rst_lt", out_lt, 0);
        check("rst_ge", out_ge, 1);
        check("rst_chunks", out_chunks, 0);
        check("rst_ready", in_ready, 1);
        #5 rst = 1'b0;
        @(posedge clk); #1;

        issue(UNSIGNED, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, w); drain();
        issue(SIGNED,   64'h8000000000000000, 64'h0000000000000001, w); drain();
        issue(UNSIGNED, 64'h8000000000000000, 64'h0000000000000001, w); drain();
        issue(UNSIGNED, 64'h000000000000FFFF, 64'h0000000000010000, w); drain();
        issue(SIGNED,   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, w); drain();
        issue(SIGNED,   64'h8000000000000000, 64'h8000000000000000, w); drain();
        issue(SIGNED,   64'h8000000000000000, 64'h0000000000000000, w); drain();

        // Backpressure: hold the result, then release and re-issue immediately.
        bp_mode = 2;
        a = 64'h1234_0000_0000_0000; b = 64'h1234_5678_0000_0000;
        e = model(UNSIGNED, a, b);
        issue(UNSIGNED, a, b, w);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("bp_valid_timeout", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_lt", out_lt, e.lt);
            check("bp_hold_eq", out_eq, e.eq);
            check("bp_hold_chunks", out_chunks, e.ch);
            check("bp_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        bp_mode = 0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        issue(UNSIGNED, 64'hDEAD, 64'hBEEF, w);
        check("bp_reaccept_waits", w, 0);
        drain();

        // Flush during the second BUSY cycle of an equal compare.
        issue(UNSIGNED, 64'hCAFEF00DCAFEF00D, 64'hCAFEF00DCAFEF00D, w);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_ready_after", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_src1 = 64'h1; in_src2 = 64'h2;
        @(negedge clk);
        check("flush_blocks_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_no_accept", in_ready, 1);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle while BUSY.
        issue(UNSIGNED, 64'h5555AAAA5555AAAA, 64'h5555AAAA5555AAAA, w);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_eq", out_eq, 0);
        check("arst_lt", out_lt, 0);
        check("arst_ge", out_ge, 1);
        check("arst_chunks", out_chunks, 0);
        #2 rst = 1'b0;
        q.delete();
        #1;
        check("arst_ready", in_ready, 1);
        @(posedge clk); #1;
        issue(SIGNED, 64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000, w); drain();

        // Randomized traffic with random backpressure and sparse differing bits.
        bp_mode = 1;
        for (int t = 0; t < 250; t++) begin
            a = {$urandom, $urandom};
            n = $urandom_range(0, 64);
            m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
            b = a ^ ({$urandom, $urandom} & m);
            if ($urandom_range(0, 7) == 0) b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a[63] = ~a[63];
            issue(sign_t'($urandom_range(0, 1)), a, b, w);
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
        end
        drain();
        bp_mode = 0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
